// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake,
// optional skid slot, synchronous flush and saturating stall/bubble counters.
module pipe_stage_reg #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 64,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t            state, state_d;
  logic [DATA_W-1:0] m_data, s_data;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;
  logic              in_xfer, out_xfer;
  logic              load_m_in, load_m_s, load_s_in;

  always_comb begin
    out_valid = (state != EMPTY);
    out_data  = m_data;
    out_ctrl  = out_valid ? m_ctrl : '0;
    // With a skid slot, readiness depends only on registered occupancy.
    if (reset || flush)
      in_ready = 1'b0;
    else if (SKID != 0)
      in_ready = (state != TWO);
    else
      in_ready = (state == EMPTY) || out_ready;
    in_xfer  = in_valid && in_ready;
    out_xfer = out_valid && out_ready;
  end

  always_comb begin
    state_d   = state;
    load_m_in = 1'b0;
    load_m_s  = 1'b0;
    load_s_in = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_d   = ONE;
          load_m_in = 1'b1;
        end
      end
      ONE: begin
        // Without a skid slot, accepting while full implies a same-cycle pop.
        if (in_xfer && out_xfer) begin
          load_m_in = 1'b1;
        end else if (in_xfer && SKID != 0) begin
          state_d   = TWO;
          load_s_in = 1'b1;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          state_d  = ONE;
          load_m_s = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= EMPTY;
      m_data <= '0;
      m_ctrl <= '0;
      s_data <= '0;
      s_ctrl <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      state <= state_d;
      if (load_m_in) begin
        m_data <= in_data;
        m_ctrl <= in_ctrl;
      end else if (load_m_s) begin
        m_data <= s_data;
        m_ctrl <= s_ctrl;
      end
      if (load_s_in) begin
        s_data <= in_data;
        s_ctrl <= in_ctrl;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || cnt_clr) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (!out_valid && out_ready && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid and a no-skid instance share stimulus and
// are each checked every cycle against a bounded-FIFO reference model.
module tb_pipe_stage_reg;
  localparam int DW = 32;
  localparam int CW = 8;
  localparam int NW = 4;
  localparam int SATV = 15;

  logic clock = 1'b0;
  logic reset, in_valid, out_ready, flush, cnt_clr;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic [1:0]    ir, ov;
  logic [DW-1:0] od [2];
  logic [CW-1:0] oc [2];
  logic [NW-1:0] sc [2];
  logic [NW-1:0] bc [2];

  int checks = 0;
  int errors = 0;

  // Reference model: index 0 = capacity-2 skid stage, 1 = capacity-1 stage.
  logic [DW+CW-1:0] mb [2][2];
  int               mn [2];
  logic [DW-1:0]    mlast [2];
  int               ms [2];
  int               mbub [2];

  always #5 clock = ~clock;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(NW)) u_skid (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .out_ctrl(oc[0]), .flush(flush), .cnt_clr(cnt_clr),
    .stall_cnt(sc[0]), .bubble_cnt(bc[0])
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(NW)) u_noskid (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .out_ctrl(oc[1]), .flush(flush), .cnt_clr(cnt_clr),
    .stall_cnt(sc[1]), .bubble_cnt(bc[1])
  );

  function automatic bit exp_ready(input int k);
    if (reset || flush) return 1'b0;
    if (k == 0) return mn[k] < 2;
    return (mn[k] == 0) || out_ready;
  endfunction

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic cycle();
    bit rdy, v;
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      chk("in_ready", k, 64'(ir[k]), 64'(exp_ready(k)));
      chk("out_valid", k, 64'(ov[k]), 64'(mn[k] > 0));
      chk("out_data", k, 64'(od[k]), mn[k] > 0 ? 64'(mb[k][0][DW+CW-1:CW]) : 64'(mlast[k]));
      chk("out_ctrl", k, 64'(oc[k]), mn[k] > 0 ? 64'(mb[k][0][CW-1:0]) : 64'd0);
      chk("stall_cnt", k, 64'(sc[k]), 64'(ms[k]));
      chk("bubble_cnt", k, 64'(bc[k]), 64'(mbub[k]));
    end
    @(posedge clock);
    for (int k = 0; k < 2; k++) begin
      rdy = exp_ready(k);
      v   = mn[k] > 0;
      if (reset) begin
        mn[k] = 0; mlast[k] = '0; ms[k] = 0; mbub[k] = 0;
      end else begin
        if (cnt_clr) begin
          ms[k] = 0; mbub[k] = 0;
        end else begin
          if (v && !out_ready && ms[k] < SATV) ms[k]++;
          if (!v && out_ready && mbub[k] < SATV) mbub[k]++;
        end
        if (flush) begin
          mn[k] = 0;
        end else begin
          if (v && out_ready) begin
            mb[k][0] = mb[k][1];
            mn[k]--;
          end
          if (rdy && in_valid) begin
            mb[k][mn[k]] = {in_data, in_ctrl};
            mn[k]++;
          end
        end
        if (mn[k] > 0) mlast[k] = mb[k][0][DW+CW-1:CW];
      end
    end
    #1;
  endtask

  task automatic step(input bit rst, input bit iv, input bit ordy, input bit fl,
                      input bit clr, input logic [DW-1:0] d, input logic [CW-1:0] c);
    reset = rst; in_valid = iv; out_ready = ordy; flush = fl; cnt_clr = clr;
    in_data = d; in_ctrl = c;
    cycle();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      mn[k] = 0; mlast[k] = '0; ms[k] = 0; mbub[k] = 0;
      mb[k][0] = '0; mb[k][1] = '0;
    end
    // Reset with a valid offer pending
    repeat (3) step(1, 1, 0, 0, 0, DW'($urandom), 8'hFF);
    step(0, 0, 1, 0, 0, '0, '0);
    // Streaming
    for (int i = 1; i <= 8; i++) step(0, 1, 1, 0, 0, DW'(i), CW'(i) ^ 8'h5A);
    repeat (2) step(0, 0, 1, 0, 0, '0, '0);
    // Backpressure into the skid slot, then drain
    step(0, 1, 0, 0, 0, 'hA, 8'h11);
    step(0, 1, 0, 0, 0, 'hB, 8'h22);
    repeat (3) step(0, 0, 0, 0, 0, '0, '0);
    repeat (3) step(0, 0, 1, 0, 0, '0, '0);
    // Flush while full with a new offer
    step(0, 1, 0, 0, 0, 'hA, 8'h11);
    step(0, 1, 0, 0, 0, 'hB, 8'h22);
    step(0, 1, 0, 1, 0, 'hC, 8'h33);
    repeat (2) step(0, 0, 1, 0, 0, '0, '0);
    // Stall counter saturation, clear during a stall, bubble saturation
    step(0, 1, 0, 0, 0, 'hD, 8'h44);
    repeat (20) step(0, 0, 0, 0, 0, '0, '0);
    step(0, 0, 0, 0, 1, '0, '0);
    repeat (3) step(0, 0, 0, 0, 0, '0, '0);
    repeat (20) step(0, 0, 1, 0, 0, '0, '0);
    step(0, 0, 1, 0, 1, '0, '0);
    // out_ready toggling with a continuous offer
    for (int i = 0; i < 12; i++) step(0, 1, 1'(i), 0, 0, DW'(256 + i), CW'(i));
    // Randomised traffic
    repeat (400)
      step($urandom_range(0, 49) == 0, 1'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
           DW'($urandom), CW'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
